// File: rtl/piso_tx_pkg.sv
// Shared types for the serial transmit controller: FSM states, requester id, arbiter pick.
// Pure declarations; no latency or backpressure of its own.
package piso_tx_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int GAP_DEF   = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  typedef logic req_id_t;

  // A lone valid requester wins; on a tie the one that did not win last time goes.
  function automatic req_id_t rr_pick(input logic [1:0] vld, input req_id_t last);
    req_id_t pick;
    pick = ~last;
    if (vld == 2'b01) pick = 1'b0;
    if (vld == 2'b10) pick = 1'b1;
    return pick;
  endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-in/serial-out shifter, MSB first, zero fill; load wins over shift.
// Loaded word's MSB is visible the cycle after load; no backpressure (controller sequences it).
module piso_shift #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_d;

  always_comb begin
    sh_d = sh_q;
    if (load_i) begin
      sh_d = data_i;
    end else if (shift_i) begin
      sh_d = {sh_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign msb_o = sh_q[WIDTH-1];

endmodule

// File: rtl/piso_tx_ctrl.sv
// Round-robin two-requester serial transmitter; each accepted word leaves MSB-first via piso_shift.
// First bit one cycle after the handshake; req_ready is raised only in IDLE with tx_en high.
module piso_tx_ctrl
  import piso_tx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int GAP   = GAP_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tx_en,
  input  logic [1:0]       req_valid,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  output logic [1:0]       req_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             grant_id,
  output logic             busy
);

  localparam int             CW     = $clog2(WIDTH);
  localparam logic [CW-1:0]  BIT_LD = CW'(WIDTH - 1);
  localparam logic [3:0]     GAP_LD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t          state_q, state_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [3:0]      gap_cnt_q, gap_cnt_d;
  req_id_t         last_q, last_d;
  req_id_t         gid_q, gid_d;
  logic            sv_q, sv_d;
  logic            sf_q, sf_d;
  logic            sl_q, sl_d;

  req_id_t         win;
  logic            accept;
  logic            load;
  logic            shift;
  logic [WIDTH-1:0] win_data;

  // Ready is gated by reset so nothing is offered while the block is held in reset.
  always_comb begin
    win       = rr_pick(req_valid, last_q);
    req_ready = 2'b00;
    if (reset_n && tx_en && (state_q == ST_IDLE) && (req_valid != 2'b00)) begin
      req_ready[win] = 1'b1;
    end
  end

  assign accept   = |(req_ready & req_valid);
  assign win_data = win ? req_data1 : req_data0;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    last_d    = last_q;
    gid_d     = gid_q;
    sv_d      = 1'b0;
    sf_d      = 1'b0;
    sl_d      = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = BIT_LD;
          load      = 1'b1;
          gid_d     = win;
          last_d    = win;
          sv_d      = 1'b1;
          sf_d      = 1'b1;
        end
      end

      ST_SHIFT: begin
        shift = 1'b1;
        if (bit_cnt_q == '0) begin
          if (GAP == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_LD;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - CW'(1);
          sv_d      = 1'b1;
          sl_d      = (bit_cnt_q == CW'(1));
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      last_q    <= 1'b1;
      gid_q     <= 1'b0;
      sv_q      <= 1'b0;
      sf_q      <= 1'b0;
      sl_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      last_q    <= last_d;
      gid_q     <= gid_d;
      sv_q      <= sv_d;
      sf_q      <= sf_d;
      sl_q      <= sl_d;
    end
  end

  piso_shift #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (load),
    .shift_i (shift),
    .data_i  (win_data),
    .msb_o   (ser_out)
  );

  assign ser_valid = sv_q;
  assign ser_first = sf_q;
  assign ser_last  = sl_q;
  assign grant_id  = gid_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Bench for piso_tx_ctrl: one instance with GAP=1 and one with GAP=0 share all inputs,
// each checked every cycle against a frame-timeline model plus directed scenario checks.
module tb_piso_tx_ctrl;

  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         tx_en;
  logic [1:0]   req_valid;
  logic [W-1:0] req_data0;
  logic [W-1:0] req_data1;

  logic [1:0] rdy [2];
  logic       so  [2];
  logic       sv  [2];
  logic       sf  [2];
  logic       sl  [2];
  logic       gid [2];
  logic       bsy [2];

  piso_tx_ctrl #(.WIDTH(W), .GAP(1)) u_g1 (
    .clk(clk), .reset_n(reset_n), .tx_en(tx_en), .req_valid(req_valid),
    .req_data0(req_data0), .req_data1(req_data1), .req_ready(rdy[0]),
    .ser_out(so[0]), .ser_valid(sv[0]), .ser_first(sf[0]), .ser_last(sl[0]),
    .grant_id(gid[0]), .busy(bsy[0])
  );

  piso_tx_ctrl #(.WIDTH(W), .GAP(0)) u_g0 (
    .clk(clk), .reset_n(reset_n), .tx_en(tx_en), .req_valid(req_valid),
    .req_data0(req_data0), .req_data1(req_data1), .req_ready(rdy[1]),
    .ser_out(so[1]), .ser_valid(sv[1]), .ser_first(sf[1]), .ser_last(sl[1]),
    .grant_id(gid[1]), .busy(bsy[1])
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: a frame is "active" from the cycle after its handshake until W+GAP cycles later.
  bit           m_act  [2];
  int           m_t    [2];
  logic [W-1:0] m_word [2];
  logic         m_gid  [2];
  logic         m_ptr  [2];

  int   first_q [$];
  logic gid_q   [$];
  logic bit_q   [$];
  logic sv1_q   [$];

  function automatic int gap_of(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_check(input int i);
    logic [1:0] er;
    logic       inb;
    logic       w;
    string      p;
    p = $sformatf("gap%0d_", gap_of(i));
    if (!reset_n) begin
      m_act[i] = 1'b0;
      m_t[i]   = 0;
      m_ptr[i] = 1'b1;
      chk({p, "rst_ready"}, rdy[i], 8'd0);
      chk({p, "rst_ser_valid"}, sv[i], 8'd0);
      chk({p, "rst_ser_first"}, sf[i], 8'd0);
      chk({p, "rst_ser_last"}, sl[i], 8'd0);
      chk({p, "rst_ser_out"}, so[i], 8'd0);
      chk({p, "rst_grant_id"}, gid[i], 8'd0);
      chk({p, "rst_busy"}, bsy[i], 8'd0);
      return;
    end
    if (m_act[i]) begin
      m_t[i]++;
      if (m_t[i] > W + gap_of(i)) m_act[i] = 1'b0;
    end
    er = 2'b00;
    w  = 1'b0;
    if (!m_act[i] && tx_en && req_valid != 2'b00) begin
      w = (req_valid == 2'b11) ? ~m_ptr[i] : req_valid[1];
      er[w] = 1'b1;
    end
    inb = m_act[i] && (m_t[i] <= W);
    chk({p, "ready"}, rdy[i], er);
    chk({p, "ser_valid"}, sv[i], inb);
    chk({p, "ser_first"}, sf[i], inb && m_t[i] == 1);
    chk({p, "ser_last"}, sl[i], inb && m_t[i] == W);
    chk({p, "busy"}, bsy[i], m_act[i]);
    if (inb) begin
      chk({p, "ser_out"}, so[i], m_word[i][W - m_t[i]]);
      chk({p, "grant_id"}, gid[i], m_gid[i]);
    end
    if ((er & req_valid) != 2'b00) begin
      m_act[i]  = 1'b1;
      m_t[i]    = 0;
      m_gid[i]  = w;
      m_ptr[i]  = w;
      m_word[i] = w ? req_data1 : req_data0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    for (int i = 0; i < 2; i++) model_check(i);
    if (sf[0] === 1'b1) begin
      first_q.push_back(cyc);
      gid_q.push_back(gid[0]);
    end
    if (sv[0] === 1'b1) bit_q.push_back(so[0]);
    sv1_q.push_back(sv[1]);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    tx_en     = 1'b0;
    req_valid = 2'b00;
    cycle();
    cycle();
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] pat4;
    logic [8:0] pat9;
    reset_n   = 1'b0;
    tx_en     = 1'b0;
    req_valid = 2'b00;
    req_data0 = '0;
    req_data1 = '0;
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 1'b0; m_t[i] = 0; m_word[i] = '0; m_gid[i] = 1'b0; m_ptr[i] = 1'b1;
    end
    do_reset();

    // Single word from requester 0.
    tx_en = 1'b1; req_valid = 2'b01; req_data0 = 4'b1011;
    bit_q.delete(); first_q.delete(); gid_q.delete();
    #1;
    chk("p1_ready_first", rdy[0], 8'h01);
    cycle();
    req_valid = 2'b00;
    repeat (6) cycle();
    pat4 = 4'b1011;
    chk("p1_nbits", 8'(bit_q.size()), 8'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("p1_bit%0d", i), bit_q[i], pat4[3-i]);
    chk("p1_grant", gid_q[0], 8'd0);

    // Both valid: alternating frames every W+GAP+1 cycles.
    do_reset();
    tx_en = 1'b1; req_valid = 2'b11; req_data0 = 4'hA; req_data1 = 4'h5;
    first_q.delete(); gid_q.delete();
    repeat (24) cycle();
    chk("p2_frames", 8'(first_q.size()), 8'd4);
    for (int j = 1; j < 4; j++) chk($sformatf("p2_spacing%0d", j), 8'(first_q[j] - first_q[j-1]), 8'd6);
    for (int j = 0; j < 4; j++) chk($sformatf("p2_grant%0d", j), gid_q[j], 8'(j % 2));

    // tx_en low blocks grants; raising it grants requester 0 at once.
    tx_en = 1'b0;
    repeat (7) cycle();
    bit_q.delete();
    repeat (10) cycle();
    chk("p3_no_bits", 8'(bit_q.size()), 8'd0);
    tx_en = 1'b1;
    #1;
    chk("p3_ready_on_enable", rdy[0], 8'h01);

    // tx_en dropped on the second bit: frame and gap still complete, no new grant.
    bit_q.delete(); first_q.delete();
    cycle();
    cycle();
    tx_en = 1'b0;
    repeat (12) cycle();
    chk("p4_nbits", 8'(bit_q.size()), 8'd4);
    chk("p4_frames", 8'(first_q.size()), 8'd1);

    // Reset on the third bit aborts the frame; pointer returns to favour requester 0.
    tx_en = 1'b1;
    cycle();
    cycle();
    cycle();
    reset_n = 1'b0;
    #1;
    chk("p5_async_ser_valid", sv[0], 8'd0);
    chk("p5_async_busy", bsy[0], 8'd0);
    cycle();
    reset_n = 1'b1;
    #1;
    chk("p5_ready_after_reset", rdy[0], 8'h01);
    chk("p5_ready_after_reset_gap0", rdy[1], 8'h01);
    repeat (8) cycle();

    // GAP=0 back-to-back frames from requester 1.
    do_reset();
    tx_en = 1'b1; req_valid = 2'b10; req_data1 = 4'h9;
    sv1_q.delete();
    repeat (12) cycle();
    req_valid = 2'b00;
    pat9 = 9'b111101111;
    for (int i = 0; i < 9; i++) chk($sformatf("p6_sv_pattern%0d", i), sv1_q[1+i], pat9[8-i]);

    // Randomized traffic with occasional reset.
    repeat (600) begin
      tx_en     = ($urandom_range(0, 7) != 0);
      req_valid = 2'($urandom_range(0, 3));
      req_data0 = W'($urandom);
      req_data1 = W'($urandom);
      reset_n   = ($urandom_range(0, 63) != 0);
      cycle();
    end
    reset_n = 1'b1;
    req_valid = 2'b00;
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
